tb_ctrl_periph: RTL and testbench

Memory-mapped test-control responder on the core data bus inside the RI5CY simulation wrapper. It accepts core loads and stores in a fixed 16-byte window and turns them into the status and output signals the testbench top monitors:

- a buffered stdout byte stream;
- sticky pass/fail flags;
- an exit event carrying a 32-bit exit code.

It is the device side of the `tests_passed` / `tests_failed` / `exit_valid` / `exit_value` interface. It also provides a cycle counter that software can read.

---
 rtl/tb_ctrl_periph.sv | 151 +++++++++++++++
 tb/tb_tb_ctrl_periph.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/tb_ctrl_periph.sv
// rtl/tb_ctrl_periph.sv - memory-mapped test-control responder (stdout FIFO, pass/fail/exit flags, cycle counter)
// Optional watchdog compiled in with TB_CTRL_WATCHDOG_EN.
module tb_ctrl_periph #(
  parameter logic [31:0] BASE_ADDR       = 32'h1000_0000,
  parameter int          FIFO_DEPTH      = 8,
  parameter logic [31:0] WATCHDOG_CYCLES = 32'd1_000_000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        stdout_valid_o,
  output logic [7:0]  stdout_data_o,
  input  logic        stdout_ready_i,
  output logic        tests_passed_o,
  output logic        tests_failed_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_value_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] REG_PRINT  = 2'd0;
  localparam logic [1:0] REG_EXIT   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CYCLES = 2'd3;

  logic             hit;
  logic [1:0]       off;
  logic             print_wr;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             terminal;
  logic             term_wr;
  logic             wd_fail;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [31:0]      cycles;
  logic [31:0]      status_word;
  logic [31:0]      read_word;

  assign hit        = (data_addr_i[31:4] == BASE_ADDR[31:4]);
  assign off        = data_addr_i[3:2];
  assign print_wr   = hit && data_we_i && (off == REG_PRINT) && data_be_i[0];
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);

  // Grant looks only at the registered count, so a same-cycle pop cannot admit a push to a full FIFO.
  assign data_gnt_o = data_req_i && !(print_wr && fifo_full);
  assign push       = data_gnt_o && print_wr;
  assign pop        = !fifo_empty && stdout_ready_i;

  assign terminal   = tests_passed_o || tests_failed_o || exit_valid_o;
  assign term_wr    = data_gnt_o && data_we_i && hit &&
                      ((off == REG_EXIT) || ((off == REG_STATUS) && (data_wdata_i != 32'd0)));

  assign stdout_valid_o = !fifo_empty;
  assign stdout_data_o  = fifo_empty ? 8'h00 : mem[rd_ptr];

  assign status_word = {16'b0, 8'(count), 4'b0, wd_fail, exit_valid_o, tests_failed_o, tests_passed_o};

  always_comb begin
    read_word = 32'd0;
    if (hit && !data_we_i) begin
      case (off)
        REG_PRINT:  read_word = 32'd0;
        REG_EXIT:   read_word = exit_value_o;
        REG_STATUS: read_word = status_word;
        REG_CYCLES: read_word = cycles;
        default:    read_word = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= data_wdata_i[7:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_rvalid_o  <= 1'b0;
      data_rdata_o   <= 32'd0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      cycles         <= 32'd0;
      tests_passed_o <= 1'b0;
      tests_failed_o <= 1'b0;
      exit_valid_o   <= 1'b0;
      exit_value_o   <= 32'd0;
`ifdef TB_CTRL_WATCHDOG_EN
      wd_fail        <= 1'b0;
`endif
    end else begin
      cycles        <= cycles + 32'd1;
      data_rvalid_o <= data_gnt_o;
      data_rdata_o  <= data_gnt_o ? read_word : 32'd0;

      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end

      // First terminal event wins; everything after it is granted but has no effect.
      if (term_wr && !terminal) begin
        if (off == REG_EXIT) begin
          exit_valid_o <= 1'b1;
          exit_value_o <= data_wdata_i;
        end else if (data_wdata_i == 32'd1) begin
          tests_passed_o <= 1'b1;
        end else begin
          tests_failed_o <= 1'b1;
        end
      end
`ifdef TB_CTRL_WATCHDOG_EN
      else if (!terminal && (cycles == WATCHDOG_CYCLES)) begin
        tests_failed_o <= 1'b1;
        wd_fail        <= 1'b1;
      end
`endif
    end
  end

`ifndef TB_CTRL_WATCHDOG_EN
  assign wd_fail = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{data_addr_i[1:0], data_be_i[3:1], WATCHDOG_CYCLES};

endmodule

// File: tb/tb_tb_ctrl_periph.sv
// tb/tb_tb_ctrl_periph.sv - directed self-checking bench for tb_ctrl_periph
// Build with TB_CTRL_WATCHDOG_EN to run the watchdog scenario instead of the bus scenarios.
module tb_tb_ctrl_periph;

  localparam logic [31:0] BASE = 32'h1000_0000;
`ifdef TB_CTRL_WATCHDOG_EN
  localparam logic [31:0] WD = 32'd100;
`else
  localparam logic [31:0] WD = 32'd1_000_000;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        gnt;
  logic        rvalid;
  logic [31:0] addr = 32'd0;
  logic        we = 1'b0;
  logic [3:0]  be = 4'h0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        so_valid;
  logic [7:0]  so_data;
  logic        so_ready = 1'b0;
  logic        passed;
  logic        failed;
  logic        exit_valid;
  logic [31:0] exit_value;

  int total = 0;
  int bad = 0;
  logic [31:0] rd;
  logic [31:0] c0;

  always #5 clk = ~clk;

  tb_ctrl_periph #(
    .BASE_ADDR(BASE),
    .FIFO_DEPTH(8),
    .WATCHDOG_CYCLES(WD)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .data_req_i(req),
    .data_gnt_o(gnt),
    .data_rvalid_o(rvalid),
    .data_addr_i(addr),
    .data_we_i(we),
    .data_be_i(be),
    .data_wdata_i(wdata),
    .data_rdata_o(rdata),
    .stdout_valid_o(so_valid),
    .stdout_data_o(so_data),
    .stdout_ready_i(so_ready),
    .tests_passed_o(passed),
    .tests_failed_o(failed),
    .exit_valid_o(exit_valid),
    .exit_value_o(exit_value)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge; returns on the negedge where rvalid should be high.
  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, output logic [31:0] r);
    int n;
    n = 0;
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    #1;
    while (gnt !== 1'b1 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("gnt", {31'b0, gnt}, 32'd1);
    @(negedge clk);
    req = 1'b0;
    chk("rvalid_after_gnt", {31'b0, rvalid}, 32'd1);
    r = rdata;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_gnt", {31'b0, gnt}, 32'd0);
    chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
    chk("rst_flags", {29'b0, passed, failed, exit_valid}, 32'd0);
    chk("rst_exit_value", exit_value, 32'd0);
    chk("rst_stdout", {23'b0, so_valid, so_data}, 32'd0);
    rst = 1'b0;

`ifdef TB_CTRL_WATCHDOG_EN
    repeat (100) @(negedge clk);
    chk("wd_not_yet", {31'b0, failed}, 32'd0);
    @(negedge clk);
    chk("wd_fired", {31'b0, failed}, 32'd1);
    bus(1'b0, BASE + 32'h8, 32'd0, 4'hF, rd);
    chk("wd_status", rd, 32'h0000_000A);
`else
    bus(1'b0, BASE + 32'hC, 32'd0, 4'hF, rd);
    chk("cycles_first", rd, 32'd0);

    so_ready = 1'b1;
    bus(1'b1, BASE, 32'h0000_0041, 4'h1, rd);
    chk("print_41", {23'b0, so_valid, so_data}, {23'b0, 1'b1, 8'h41});
    chk("write_rdata_zero", rd, 32'd0);
    bus(1'b1, BASE, 32'h0000_0042, 4'h1, rd);
    chk("print_42", {23'b0, so_valid, so_data}, {23'b0, 1'b1, 8'h42});
    @(negedge clk);
    chk("stream_drained", {31'b0, so_valid}, 32'd0);

    so_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus(1'b1, BASE, 32'h10 + i, 4'h1, rd);
    end
    bus(1'b0, BASE + 32'h8, 32'd0, 4'hF, rd);
    chk("status_full", rd, 32'h0000_0800);
    chk("head_full", {24'b0, so_data}, 32'h10);
    req = 1'b1; we = 1'b1; addr = BASE; wdata = 32'h18; be = 4'h1;
    #1;
    chk("ninth_blocked", {31'b0, gnt}, 32'd0);
    @(negedge clk);
    #1;
    chk("ninth_still_blocked", {31'b0, gnt}, 32'd0);
    so_ready = 1'b1;
    #1;
    chk("pop_same_cycle_blocks", {31'b0, gnt}, 32'd0);
    @(negedge clk);
    so_ready = 1'b0;
    #1;
    chk("ninth_granted", {31'b0, gnt}, 32'd1);
    @(negedge clk);
    req = 1'b0;
    chk("ninth_rvalid", {31'b0, rvalid}, 32'd1);
    bus(1'b0, BASE + 32'h8, 32'd0, 4'hF, rd);
    chk("status_refill", rd, 32'h0000_0800);
    so_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("drain_byte", {24'b0, so_data}, 32'h10 + i);
      @(negedge clk);
    end
    chk("drain_empty", {31'b0, so_valid}, 32'd0);
    so_ready = 1'b0;

    bus(1'b1, BASE + 32'h4, 32'd5, 4'hF, rd);
    chk("exit_valid", {31'b0, exit_valid}, 32'd1);
    chk("exit_value", exit_value, 32'd5);
    bus(1'b1, BASE + 32'h8, 32'd1, 4'hF, rd);
    chk("pass_after_exit", {31'b0, passed}, 32'd0);
    bus(1'b0, BASE + 32'h4, 32'd0, 4'hF, rd);
    chk("read_exit", rd, 32'd5);
    bus(1'b0, BASE + 32'h8, 32'd0, 4'hF, rd);
    chk("status_exit", rd, 32'h0000_0004);

    do_reset();
    bus(1'b1, BASE + 32'h8, 32'd1, 4'hF, rd);
    chk("passed_set", {31'b0, passed}, 32'd1);
    bus(1'b1, BASE, 32'h55, 4'h1, rd);
    chk("push_before_rst", {31'b0, so_valid}, 32'd1);
    req = 1'b1; we = 1'b0; addr = BASE + 32'h8; be = 4'hF;
    #1;
    chk("gnt_before_rst", {31'b0, gnt}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    req = 1'b0;
    chk("rst_mid_outputs", {26'b0, rvalid, passed, failed, exit_valid, so_valid, |so_data}, 32'd0);
    chk("rst_mid_rdata", rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("no_stray_rvalid", {31'b0, rvalid}, 32'd0);

    bus(1'b0, BASE + 32'hC, 32'd0, 4'hF, rd);
    c0 = rd;
    repeat (9) @(negedge clk);
    bus(1'b0, BASE + 32'hC, 32'd0, 4'hF, rd);
    chk("cycles_diff", rd - c0, 32'd10);
    bus(1'b0, 32'h2000_0008, 32'd0, 4'hF, rd);
    chk("miss_read", rd, 32'd0);
    bus(1'b1, 32'h2000_0008, 32'd1, 4'hF, rd);
    chk("miss_write_dropped", {31'b0, passed}, 32'd0);
    bus(1'b1, BASE + 32'h8, 32'd7, 4'hF, rd);
    chk("failed_set", {30'b0, failed, passed}, 32'd2);
    bus(1'b0, BASE + 32'h8, 32'd0, 4'hF, rd);
    chk("status_failed", rd, 32'h0000_0002);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
